// File: rtl/mm_tile_sched.sv
// Matrix-tile issue scheduler: walks b/k/col/row loops, drives operand reads, accumulator writes and result drain.
// Optional macro MM_SCHED_PERF_CNT_EN adds busy/stall cycle counters on o_busy_cyc/o_stall_cyc.
module mm_tile_sched #(
  parameter int unsigned VL    = 16,
  parameter int unsigned DIM_W = 8,
  parameter int unsigned AA_W  = 12,
  parameter int unsigned AB_W  = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [1:0]                        i_mode,
  input  logic [DIM_W-1:0]                  i_m_tiles,
  input  logic [DIM_W-1:0]                  i_n_tiles,
  input  logic [DIM_W-1:0]                  i_k_steps,
  input  logic                              i_stall,
  output logic                              o_busy,
  output logic                              o_err,
  output logic [1:0]                        o_mode,
  output logic                              o_rd_en,
  output logic [AA_W-1:0]                   o_a_addr,
  output logic [AB_W-1:0]                   o_b_addr,
  output logic                              o_acc_we,
  output logic [((VL > 1) ? $clog2(VL) : 1)-1:0] o_acc_addr,
  output logic                              o_psum_clr,
  output logic                              o_out_valid,
  output logic [((VL > 1) ? $clog2(VL) : 1)-1:0] o_out_addr,
  input  logic                              i_out_ready,
  output logic                              o_tile_done,
  output logic                              o_mtrx_done,
  output logic [31:0]                       o_busy_cyc,
  output logic [31:0]                       o_stall_cyc
);

  localparam int unsigned BW = (VL > 1) ? $clog2(VL) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(VL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     b_cnt, rd_b;
  logic [DIM_W-1:0]  k_cnt, col, row;
  logic [DIM_W-1:0]  m_q, n_q, k_q;
  logic              rd_kz;
  logic              issue_c, start_ok_c, start_bad_c, drain_fire_c, drain_end_c;
  logic              last_b_c, last_k_c, last_col_c, last_row_c, dims_ok_c;

  assign last_b_c   = (b_cnt == B_LAST);
  assign last_k_c   = (k_cnt == k_q - DIM_W'(1));
  assign last_col_c = (col == n_q - DIM_W'(1));
  assign last_row_c = (row == m_q - DIM_W'(1));
  assign dims_ok_c  = (i_m_tiles != '0) && (i_n_tiles != '0) && (i_k_steps != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-cycle event decode; abort overrides everything.
  always_comb begin
    state_nx     = state;
    issue_c      = 1'b0;
    start_ok_c   = 1'b0;
    start_bad_c  = 1'b0;
    drain_fire_c = 1'b0;
    drain_end_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (dims_ok_c) begin
            start_ok_c = 1'b1;
            state_nx   = S_RUN;
          end else begin
            start_bad_c = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!i_stall) begin
          issue_c = 1'b1;
          if (last_b_c && last_k_c) state_nx = S_FLUSH;
        end
      end
      S_FLUSH: state_nx = S_DRAIN;
      S_DRAIN: begin
        if (i_out_ready) begin
          drain_fire_c = 1'b1;
          if (o_out_addr == B_LAST) begin
            drain_end_c = 1'b1;
            state_nx    = (last_col_c && last_row_c) ? S_IDLE : S_RUN;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (i_abort) begin
      state_nx     = S_IDLE;
      issue_c      = 1'b0;
      start_ok_c   = 1'b0;
      start_bad_c  = 1'b0;
      drain_fire_c = 1'b0;
      drain_end_c  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      o_mode      <= '0;
      o_rd_en     <= 1'b0;
      o_a_addr    <= '0;
      o_b_addr    <= '0;
      o_acc_we    <= 1'b0;
      o_acc_addr  <= '0;
      o_psum_clr  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_addr  <= '0;
      o_tile_done <= 1'b0;
      o_mtrx_done <= 1'b0;
      b_cnt       <= '0;
      k_cnt       <= '0;
      col         <= '0;
      row         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      rd_b        <= '0;
      rd_kz       <= 1'b0;
    end else begin
      o_busy      <= (state_nx != S_IDLE);
      o_out_valid <= (state_nx == S_DRAIN);
      o_err       <= start_bad_c;
      o_tile_done <= drain_end_c;
      o_mtrx_done <= drain_end_c && last_col_c && last_row_c;
      o_rd_en     <= issue_c;
      // Accumulator side trails the read by one cycle.
      o_acc_we    <= o_rd_en && !i_abort;
      o_psum_clr  <= o_rd_en && rd_kz && !i_abort;
      o_acc_addr  <= i_abort ? '0 : rd_b;

      if (start_ok_c) begin
        o_mode     <= i_mode;
        m_q        <= i_m_tiles;
        n_q        <= i_n_tiles;
        k_q        <= i_k_steps;
        b_cnt      <= '0;
        k_cnt      <= '0;
        col        <= '0;
        row        <= '0;
        o_out_addr <= '0;
      end

      if (issue_c) begin
        o_a_addr <= AA_W'(32'(k_cnt) + 32'(row) * 32'(k_q));
        o_b_addr <= AB_W'(32'(b_cnt) + 32'(k_cnt) * 32'(n_q) * 32'(VL) + 32'(col) * 32'(VL));
        rd_b     <= b_cnt;
        rd_kz    <= (k_cnt == '0);
        if (last_b_c) begin
          b_cnt <= '0;
          k_cnt <= last_k_c ? '0 : k_cnt + DIM_W'(1);
        end else begin
          b_cnt <= b_cnt + BW'(1);
        end
      end

      if (drain_fire_c) begin
        if (drain_end_c) begin
          o_out_addr <= '0;
          if (last_col_c) begin
            col <= '0;
            row <= last_row_c ? '0 : row + DIM_W'(1);
          end else begin
            col <= col + DIM_W'(1);
          end
        end else begin
          o_out_addr <= o_out_addr + BW'(1);
        end
      end

      if (i_abort) begin
        rd_b       <= '0;
        rd_kz      <= 1'b0;
        o_out_addr <= '0;
      end
    end
  end

`ifdef MM_SCHED_PERF_CNT_EN
  logic [31:0] busy_cyc_q, stall_cyc_q;

  // Saturating activity counters, cleared by an accepted start and frozen in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else if (start_ok_c) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      if ((state != S_IDLE) && (busy_cyc_q != '1)) busy_cyc_q <= busy_cyc_q + 32'd1;
      if ((state == S_RUN) && i_stall && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign o_busy_cyc  = busy_cyc_q;
  assign o_stall_cyc = stall_cyc_q;
`else
  assign o_busy_cyc  = '0;
  assign o_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mm_tile_sched.sv
// Randomized bench for mm_tile_sched against a loop-nest reference model of issue, accumulate and drain streams.
module tb_mm_tile_sched;

  localparam int VL    = 16;
  localparam int DIM_W = 8;
  localparam int AA_W  = 12;
  localparam int AB_W  = 16;
  localparam int BW    = $clog2(VL);

  logic             clk = 1'b0;
  logic             i_rst, i_start, i_abort, i_stall, i_out_ready;
  logic [1:0]       i_mode;
  logic [DIM_W-1:0] i_m_tiles, i_n_tiles, i_k_steps;
  logic             o_busy, o_err, o_rd_en, o_acc_we, o_psum_clr, o_out_valid;
  logic             o_tile_done, o_mtrx_done;
  logic [1:0]       o_mode;
  logic [AA_W-1:0]  o_a_addr;
  logic [AB_W-1:0]  o_b_addr;
  logic [BW-1:0]    o_acc_addr, o_out_addr;
  logic [31:0]      o_busy_cyc, o_stall_cyc;

  mm_tile_sched #(.VL(VL), .DIM_W(DIM_W), .AA_W(AA_W), .AB_W(AB_W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_m_tiles(i_m_tiles), .i_n_tiles(i_n_tiles), .i_k_steps(i_k_steps), .i_stall(i_stall),
    .o_busy(o_busy), .o_err(o_err), .o_mode(o_mode), .o_rd_en(o_rd_en),
    .o_a_addr(o_a_addr), .o_b_addr(o_b_addr), .o_acc_we(o_acc_we), .o_acc_addr(o_acc_addr),
    .o_psum_clr(o_psum_clr), .o_out_valid(o_out_valid), .o_out_addr(o_out_addr),
    .i_out_ready(i_out_ready), .o_tile_done(o_tile_done), .o_mtrx_done(o_mtrx_done),
    .o_busy_cyc(o_busy_cyc), .o_stall_cyc(o_stall_cyc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference streams produced straight from the loop nest.
  int exp_a[$], exp_b[$], exp_acc[$], exp_clr[$], exp_drain[$];
  int tile_stamps[$];
  int rd_cnt, drain_cyc, tiles_seen, mtrx_seen, cyc, last_a, last_b;

  task automatic clear_model();
    exp_a.delete(); exp_b.delete(); exp_acc.delete(); exp_clr.delete(); exp_drain.delete();
    tile_stamps.delete();
    rd_cnt = 0; drain_cyc = 0; tiles_seen = 0; mtrx_seen = 0;
  endtask

  task automatic build_model(input int m, input int n, input int k);
    clear_model();
    for (int r = 0; r < m; r++)
      for (int c = 0; c < n; c++) begin
        for (int kk = 0; kk < k; kk++)
          for (int b = 0; b < VL; b++) begin
            exp_a.push_back((kk + r * k) % (1 << AA_W));
            exp_b.push_back((b + kk * n * VL + c * VL) % (1 << AB_W));
            exp_acc.push_back(b);
            exp_clr.push_back(kk == 0 ? 1 : 0);
          end
        for (int d = 0; d < VL; d++) exp_drain.push_back(d);
      end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (o_rd_en) begin
      rd_cnt++;
      if (exp_a.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        last_a = exp_a.pop_front();
        last_b = exp_b.pop_front();
        chk("a_addr", o_a_addr, last_a);
        chk("b_addr", o_b_addr, last_b);
      end
    end
    if (o_acc_we) begin
      if (exp_acc.size() == 0) chk("acc_unexpected", 1, 0);
      else begin
        chk("acc_addr", o_acc_addr, exp_acc.pop_front());
        chk("psum_clr", o_psum_clr, exp_clr.pop_front());
      end
    end
    if (o_out_valid) begin
      drain_cyc++;
      if (i_out_ready) begin
        if (exp_drain.size() == 0) chk("drain_unexpected", 1, 0);
        else chk("out_addr", o_out_addr, exp_drain.pop_front());
      end
    end
    if (o_tile_done) begin
      tiles_seen++;
      tile_stamps.push_back(cyc);
    end
    if (o_mtrx_done) begin
      mtrx_seen++;
      chk("mtrx_with_tile", o_tile_done, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int m, input int n, input int k, input int md);
    build_model(m, n, k);
    i_m_tiles = DIM_W'(m); i_n_tiles = DIM_W'(n); i_k_steps = DIM_W'(k);
    i_mode = 2'(md); i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("busy_start", o_busy, 1);
    chk("mode_latch", o_mode, md);
  endtask

  task automatic wait_done(input int budget, input int stall_pct, input int nrdy_pct);
    int n = 0;
    while (mtrx_seen == 0 && n < budget) begin
      i_stall     = ($urandom_range(99) < stall_pct);
      i_out_ready = !($urandom_range(99) < nrdy_pct);
      step();
      n++;
    end
  endtask

  task automatic finish_job(input int m, input int n, input int k, input int md);
    i_stall = 1'b0; i_out_ready = 1'b1;
    step(); step();
    chk("job_done", mtrx_seen, 1);
    chk("tiles", tiles_seen, m * n);
    chk("rd_total", rd_cnt, m * n * k * VL);
    chk("rd_left", exp_a.size(), 0);
    chk("acc_left", exp_acc.size(), 0);
    chk("drain_left", exp_drain.size(), 0);
    chk("busy_end", o_busy, 0);
    chk("mode_hold", o_mode, md);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit held;
    int n;
    int exp_stall, exp_busy;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_stall = 1'b0; i_out_ready = 1'b1;
    i_mode = '0; i_m_tiles = '0; i_n_tiles = '0; i_k_steps = '0;
    clear_model();
    repeat (3) step();
    i_rst = 1'b0;
    step();
    chk("rst_busy", o_busy, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_a_addr", o_a_addr, 0);
    chk("rst_b_addr", o_b_addr, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_busy_cyc", o_busy_cyc, 0);

    // 2x2x4 streaming job without backpressure.
    start_job(2, 2, 4, 0);
    wait_done(2000, 0, 0);
    finish_job(2, 2, 4, 0);
    chk("drain_cycles_full", drain_cyc, 4 * VL);
    chk("tile_stamp_count", tile_stamps.size(), 4);
    for (int i = 1; i < tile_stamps.size(); i++)
      chk("tile_period", tile_stamps[i] - tile_stamps[i-1], VL * 4 + 1 + VL);

    // Five stall cycles in the middle of the second k-step.
    start_job(1, 1, 2, 1);
    repeat (20) step();
    i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_rd_en", o_rd_en, 0);
      chk("stall_a_hold", o_a_addr, last_a);
      chk("stall_b_hold", o_b_addr, last_b);
    end
    i_stall = 1'b0;
`ifdef MM_SCHED_PERF_CNT_EN
    exp_stall = 5;
    exp_busy  = VL * 2 + 5 + 1 + VL;
`else
    exp_stall = 0;
    exp_busy  = 0;
`endif
    chk("stall_cyc", o_stall_cyc, exp_stall);
    wait_done(2000, 0, 0);
    finish_job(1, 1, 2, 1);
    chk("stall_cyc_end", o_stall_cyc, exp_stall);
    chk("busy_cyc_end", o_busy_cyc, exp_busy);

    // Drain backpressure for three cycles at address 7.
    start_job(1, 1, 1, 2);
    held = 1'b0;
    n = 0;
    while (mtrx_seen == 0 && n < 500) begin
      if (!held && o_out_valid && o_out_addr == BW'(7)) begin
        i_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          step();
          chk("bp_valid", o_out_valid, 1);
          chk("bp_addr", o_out_addr, 7);
        end
        i_out_ready = 1'b1;
        held = 1'b1;
      end else begin
        step();
      end
      n++;
    end
    finish_job(1, 1, 1, 2);
    chk("drain_cycles_bp", drain_cyc, 19);

    // Zero-dimension starts are rejected.
    i_m_tiles = 8'd1; i_n_tiles = 8'd1; i_k_steps = 8'd0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("err_pulse", o_err, 1);
    chk("err_busy", o_busy, 0);
    step();
    chk("err_clear", o_err, 0);
    chk("err_busy2", o_busy, 0);
    i_m_tiles = 8'd0; i_k_steps = 8'd3; i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("err_m0", o_err, 1);

    // Abort during RUN, then abort racing start in IDLE, then a clean restart.
    start_job(2, 2, 2, 3);
    repeat (10) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_rd_en", o_rd_en, 0);
    chk("abort_acc_we", o_acc_we, 0);
    chk("abort_valid", o_out_valid, 0);
    clear_model();
    repeat (3) step();
    chk("abort_no_tile", tiles_seen, 0);
    chk("abort_no_mtrx", mtrx_seen, 0);
    i_m_tiles = 8'd1; i_n_tiles = 8'd1; i_k_steps = 8'd1; i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    chk("abort_wins", o_busy, 0);
    start_job(1, 2, 1, 1);
    wait_done(2000, 0, 0);
    finish_job(1, 2, 1, 1);

    // Asynchronous reset in the middle of DRAIN.
    start_job(1, 1, 1, 2);
    n = 0;
    while (!o_out_valid && n < 200) begin
      step();
      n++;
    end
    repeat (4) step();
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_out_valid, 0);
    chk("arst_out_addr", o_out_addr, 0);
    chk("arst_rd_en", o_rd_en, 0);
    chk("arst_a_addr", o_a_addr, 0);
    chk("arst_b_addr", o_b_addr, 0);
    chk("arst_mode", o_mode, 0);
    chk("arst_acc_we", o_acc_we, 0);
    clear_model();
    step(); step();
    i_rst = 1'b0;
    step();
    chk("arst_no_tile", tiles_seen, 0);
    chk("arst_idle", o_busy, 0);

    // Randomized jobs with random stall and drain backpressure.
    for (int j = 0; j < 4; j++) begin
      int m, nn, k, md;
      m  = $urandom_range(3, 1);
      nn = $urandom_range(3, 1);
      k  = $urandom_range(3, 1);
      md = $urandom_range(2);
      start_job(m, nn, k, md);
      wait_done(5000, 30, 30);
      finish_job(m, nn, k, md);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_tile_sched.md
MM_TILE_SCHED -- requirements
Module: mm_tile_sched

Interface
REQ-001 SHALL have parameter VL, default 16: lanes per tile, which is also the accumulator depth and the B vectors per k-step.
REQ-002 SHALL have parameter DIM_W, default 8: width of the runtime tile-count inputs.
REQ-003 SHALL have parameters AA_W, default 12, and AB_W, default 16: A and B address widths.
REQ-004 SHALL have ports i_clk in 1 (clock) and i_rst in 1 (reset); one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports i_start in 1, i_abort in 1 and i_mode in 2 (0 INT8, 1 INT4, 2 INT4_VSQ).
REQ-006 SHALL have ports i_m_tiles, i_n_tiles and i_k_steps, each in DIM_W: runtime dimensions in tiles.
REQ-007 SHALL have port i_stall in 1: operand not available, freeze issue.
REQ-008 SHALL have ports o_busy out 1, o_err out 1 and o_mode out 2 (latched mode).
REQ-009 SHALL have ports o_rd_en out 1, o_a_addr out AA_W and o_b_addr out AB_W: operand buffer reads.
REQ-010 SHALL have ports o_acc_we out 1, o_acc_addr out clog2(VL) and o_psum_clr out 1: accumulator write control.
REQ-011 SHALL have ports o_out_valid out 1, o_out_addr out clog2(VL) and i_out_ready in 1: result drain handshake.
REQ-012 SHALL have ports o_tile_done out 1 and o_mtrx_done out 1: one-cycle pulses.
REQ-013 SHALL have ports o_busy_cyc out 32 and o_stall_cyc out 32: performance counters.

Function
REQ-014 SHALL implement states IDLE, RUN, FLUSH and DRAIN; o_busy SHALL be 1 in every state except IDLE.
REQ-015 IDLE: on i_start with all three dimensions nonzero, SHALL latch mode and dimensions, clear counters and go to RUN.
REQ-016 IDLE: on i_start with any dimension equal to 0, SHALL pulse o_err for 1 cycle and stay in IDLE.
REQ-017 SHALL ignore i_start in any state other than IDLE.
REQ-018 Counters SHALL be b_cnt 0..VL-1 (innermost), k_cnt 0..k_steps-1, col 0..n_tiles-1 and row 0..m_tiles-1 (outermost); each SHALL wrap to 0 and carry to the next.
REQ-019 Addresses SHALL be o_a_addr = k_cnt + row*k_steps and o_b_addr = b_cnt + k_cnt*n_tiles*VL + col*VL, each truncated to its port width.
REQ-020 RUN, i_stall=0: SHALL assert o_rd_en, drive the addresses and advance b_cnt/k_cnt by one step per cycle.
REQ-021 RUN, i_stall=1: SHALL hold o_rd_en=0 and hold all counters.
REQ-022 Accumulator control SHALL lag the read by exactly 1 cycle: o_acc_we = o_rd_en delayed 1, o_acc_addr = b_cnt delayed 1, o_psum_clr = (k_cnt==0) delayed 1.
REQ-023 The issue with b_cnt=VL-1 and k_cnt=k_steps-1 SHALL move the FSM to FLUSH, which lasts 1 cycle so the final acc write completes.
REQ-024 FLUSH SHALL then go to DRAIN.
REQ-025 DRAIN: o_out_valid=1 with o_out_addr counting 0..VL-1; the address SHALL advance only when o_out_valid and i_out_ready are both 1.
REQ-026 DRAIN: o_out_valid and o_out_addr SHALL stay stable while i_out_ready=0.
REQ-027 On acceptance of drain address VL-1, SHALL pulse o_tile_done, advance col/row and return to RUN.
REQ-028 If that tile was the last (col=n_tiles-1, row=m_tiles-1), SHALL pulse o_mtrx_done in the same cycle as o_tile_done and go to IDLE.
REQ-029 i_abort SHALL force IDLE next cycle from any state and clear o_rd_en, o_acc_we, o_out_valid and the pipeline stage; it SHALL produce no done pulse.
REQ-030 When i_abort and i_start are high in the same cycle, i_abort SHALL win.
REQ-031 The 1x1x1 dimension case SHALL be legal: VL reads, FLUSH, drain, then both done pulses.
REQ-032 o_mode SHALL hold the latched mode until the next accepted start.

Reset
REQ-033 Under i_rst: state = IDLE; all counters, addresses and outputs = 0; o_mode = 0.
REQ-034 Asserting i_rst mid-operation SHALL produce the same result as REQ-033 immediately, with no done pulse.

Configuration
REQ-035 Macro MM_SCHED_PERF_CNT_EN: when defined, o_busy_cyc SHALL count cycles with o_busy=1.
REQ-036 When MM_SCHED_PERF_CNT_EN is defined, o_stall_cyc SHALL count RUN cycles with i_stall=1.
REQ-037 When MM_SCHED_PERF_CNT_EN is defined, both counters SHALL clear on accepted start, saturate at 2^32-1 and hold in IDLE.
REQ-038 When MM_SCHED_PERF_CNT_EN is not defined, both ports SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-039 Bench SHALL cover: VL=16, dims 2/2/4, no stall, i_out_ready=1 -> 4 tiles; each tile 64 reads, FLUSH, 16 drains; o_b_addr sequence 0..15, 32..47, 64..79, 96..111 on tile 0; o_mtrx_done once, coincident with the 4th o_tile_done.
REQ-040 Bench SHALL cover: i_stall high for 5 cycles mid-k-step -> counters and addresses frozen; o_stall_cyc=5 with the macro, 0 without.
REQ-041 Bench SHALL cover: i_out_ready low 3 cycles in DRAIN at o_out_addr=7 -> o_out_valid=1 and o_out_addr=7 held; drain totals 19 cycles.
REQ-042 Bench SHALL cover: start with i_k_steps=0 -> o_err pulse of 1 cycle, o_busy stays 0.
REQ-043 Bench SHALL cover: i_abort in RUN at cycle 10 -> next cycle IDLE, o_rd_en=o_acc_we=0, no done pulse; a restart then runs clean.
REQ-044 Bench SHALL cover: i_rst asserted asynchronously mid-DRAIN -> all outputs 0 before the next clock edge.
